dbg_run_ctrl: RTL

Run-control and profiling unit between the serial debug unit and the multicycle CPU. It replaces the free-running CPU clock with a clock enable and adds host commands: run, halt, single-step and N-step. It also provides NUM_BP hardware PC breakpoints and wide saturating cycle and instruction counters. Commands arrive from the SDU command decoder; the CPU's datapath registers are gated by `cpu_ce`.

---
 rtl/dbg_run_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: run control and profiling unit sitting between the serial
// debug unit and the multicycle CPU. Instead of a free-running clock it drives
// a CPU clock enable. Host commands can run, halt, single-step or N-step the
// CPU. It also has NUM_BP PC breakpoints and saturating cycle and instruction
// counters.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cmd_valid         command strobe (always accepted, o_cmd_ready = 1)
//   i_cmd_op            0 NOP,1 RUN,2 STEP_N,3 HALT,4 SET_BP,5 CLR_BP,
//                       6 CLR_CNT,7 CLR_ALL_BP
//   i_cmd_idx           breakpoint index for SET_BP / CLR_BP
//   i_cmd_data          breakpoint address (SET_BP) or step count (STEP_N)
//   i_pc_chk, i_fetch   PC of the next instruction, valid in CPU fetch state
//   o_cpu_ce            CPU clock enable
//   o_halted            unit is in HALT
//   o_halt_cause        0 RESET, 1 HOST, 2 BREAKPOINT, 3 STEP_DONE
//   o_bp_hit_idx        breakpoint responsible for the last breakpoint halt
//   o_cycles, o_instrs  saturating counts of enabled cycles / executed fetches
module dbg_run_ctrl #(
    parameter  int PC_W   = 32,
    parameter  int NUM_BP = 4,
    parameter  int CNT_W  = 32,
    localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [IDX_W-1:0] i_cmd_idx,
    input  logic [PC_W-1:0]  i_cmd_data,
    input  logic [PC_W-1:0]  i_pc_chk,
    input  logic             i_fetch,
    output logic             o_cpu_ce,
    output logic             o_halted,
    output logic [1:0]       o_halt_cause,
    output logic [IDX_W-1:0] o_bp_hit_idx,
    output logic [CNT_W-1:0] o_cycles,
    output logic [CNT_W-1:0] o_instrs
);

    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_STEP_N  = 3'd2;
    localparam logic [2:0] OP_HALT    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_CNT = 3'd6;
    localparam logic [2:0] OP_CLR_ALL = 3'd7;

    localparam logic [1:0] CAUSE_RESET = 2'd0;
    localparam logic [1:0] CAUSE_HOST  = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_STEP  = 2'd3;

    typedef enum logic [1:0] {ST_HALT = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2} state_t;

    state_t                        r_state, w_state_nxt;
    logic [1:0]                    r_cause, w_cause_nxt;
    logic [IDX_W-1:0]              r_hit_idx, w_hit_idx_nxt;
    logic [NUM_BP-1:0]             r_bp_en;
    logic [NUM_BP-1:0][PC_W-1:0]   r_bp_addr;
    logic [PC_W-1:0]               r_remaining;
    logic                          r_skip;
    logic [CNT_W-1:0]              r_cycles, r_instrs;

    logic             w_running, w_bp_any, w_bp_term, w_step_term, w_stop, w_ce, w_go;
    logic [IDX_W-1:0] w_bp_idx;
    logic             w_clr_cnt;

    // Lowest matching index wins: scan downwards so lower indices overwrite.
    always_comb begin
        w_bp_any = 1'b0;
        w_bp_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (r_bp_en[i] && (r_bp_addr[i] == i_pc_chk)) begin
                w_bp_any = 1'b1;
                w_bp_idx = IDX_W'(i);
            end
        end
    end

    assign w_running   = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_bp_term   = i_fetch && w_running && w_bp_any && !r_skip;
    assign w_step_term = i_fetch && (r_state == ST_STEP) && (r_remaining == '0);
    assign w_stop      = w_bp_term || w_step_term;
    // The stopping fetch never executes, so the CPU PC stays on it.
    assign w_ce        = (r_state != ST_HALT) && !w_stop;
    assign w_clr_cnt   = i_cmd_valid && (i_cmd_op == OP_CLR_CNT);

    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_cause;
        w_hit_idx_nxt = r_hit_idx;
        w_go          = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (i_cmd_valid && i_cmd_op == OP_RUN) begin
                    w_state_nxt = ST_RUN;
                    w_go        = 1'b1;
                end else if (i_cmd_valid && i_cmd_op == OP_STEP_N) begin
                    w_state_nxt = ST_STEP;
                    w_go        = 1'b1;
                end
            end
            default: begin
                // A stop outranks a same-cycle HALT command for the cause.
                if (w_stop) begin
                    w_state_nxt = ST_HALT;
                    if (w_bp_term) begin
                        w_cause_nxt   = CAUSE_BP;
                        w_hit_idx_nxt = w_bp_idx;
                    end else begin
                        w_cause_nxt = CAUSE_STEP;
                    end
                end else if (i_cmd_valid && i_cmd_op == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_HOST;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_HALT;
            r_cause     <= CAUSE_RESET;
            r_hit_idx   <= '0;
            r_bp_en     <= '0;
            r_bp_addr   <= '0;
            r_remaining <= '0;
            r_skip      <= 1'b0;
            r_cycles    <= '0;
            r_instrs    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_hit_idx <= w_hit_idx_nxt;

            // Resuming from a breakpoint must execute the instruction it stopped on.
            if (w_go)
                r_skip <= 1'b1;
            else if (i_fetch && w_ce)
                r_skip <= 1'b0;

            // An executing fetch in STEP implies remaining != 0, so no underflow.
            if (w_go && i_cmd_op == OP_STEP_N)
                r_remaining <= (i_cmd_data == '0) ? PC_W'(1) : i_cmd_data;
            else if (r_state == ST_STEP && i_fetch && w_ce)
                r_remaining <= r_remaining - PC_W'(1);

            if (i_cmd_valid) begin
                case (i_cmd_op)
                    OP_SET_BP: begin
                        r_bp_en[i_cmd_idx]   <= 1'b1;
                        r_bp_addr[i_cmd_idx] <= i_cmd_data;
                    end
                    OP_CLR_BP:  r_bp_en[i_cmd_idx] <= 1'b0;
                    OP_CLR_ALL: r_bp_en <= '0;
                    default: ;
                endcase
            end

            if (w_clr_cnt)
                r_cycles <= '0;
            else if (w_ce && r_cycles != {CNT_W{1'b1}})
                r_cycles <= r_cycles + CNT_W'(1);

            if (w_clr_cnt)
                r_instrs <= '0;
            else if (w_ce && i_fetch && r_instrs != {CNT_W{1'b1}})
                r_instrs <= r_instrs + CNT_W'(1);
        end
    end

    assign o_cmd_ready  = 1'b1;
    assign o_cpu_ce     = w_ce;
    assign o_halted     = (r_state == ST_HALT);
    assign o_halt_cause = r_cause;
    assign o_bp_hit_idx = r_hit_idx;
    assign o_cycles     = r_cycles;
    assign o_instrs     = r_instrs;

endmodule
